// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting four cores serialized access to one synchronous memory port.
// Each transaction walks IDLE -> GRANT -> ACCESS -> RESP and its request fields are latched at grant.
module mem_arbiter #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8
) (
  input  logic                   clk,
  input  logic                   resetARB,
  input  logic [NCORES-1:0]      core_req,
  input  logic [NCORES-1:0]      core_we,
  input  logic [NCORES*AW-1:0]   core_addr,
  input  logic [NCORES*DW-1:0]   core_wdata,
  output logic [NCORES-1:0]      core_gnt,
  output logic [NCORES-1:0]      core_done,
  output logic [DW-1:0]          core_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   busy,
  output logic [1:0]             owner
);

  typedef enum logic [1:0] {StIdle, StGrant, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d, owner_q, owner_d;
  logic [NCORES-1:0] mask_q, mask_d, elig;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NCORES-1:0] gnt_q, gnt_d, done_q, done_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [1:0]        winner, idx;
  logic              found;

  // Previous owner is masked for one IDLE cycle so a late req drop cannot re-grant it.
  assign elig = core_req & ~mask_q;

  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NCORES; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetARB) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      mask_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mask_q      <= mask_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    mask_d  = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          owner_d = winner;
          we_d    = core_we[winner];
          addr_d  = core_addr[winner*AW +: AW];
          wdata_d = core_wdata[winner*DW +: DW];
        end
      end
      StGrant:  state_d = StAccess;
      StAccess: state_d = StResp;
      StResp: begin
        state_d         = StIdle;
        ptr_d           = owner_q + 2'd1;
        owner_d         = '0;
        mask_d[owner_q] = 1'b1;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    gnt_d       = '0;
    done_d      = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    busy_d      = (state_d != StIdle);
    unique case (state_d)
      StGrant:  gnt_d[owner_d] = 1'b1;
      StAccess: begin
        mem_en_d    = 1'b1;
        mem_we_d    = we_q;
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
      end
      StResp:   done_d[owner_d] = 1'b1;
      default:  ;
    endcase
    if (state_q == StResp && !we_q) rdata_d = mem_rdata;
  end

  // Read data arrives from the memory during RESP; pass it through then and hold it afterwards.
  assign core_rdata = (state_q == StResp && !we_q) ? mem_rdata : rdata_q;
  assign core_gnt   = gnt_q;
  assign core_done  = done_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level reference model predicts
// grant order, memory strobes, completions and read data, and a negedge monitor checks them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetARB;
  logic [3:0]  core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_gnt, core_done;
  logic [7:0]  core_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .resetARB   (resetARB),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_done  (core_done),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .owner      (owner)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h15) ? 8'hA7 : ((a ^ 8'h5C) + 8'd3);
  endfunction

  // Synchronous memory seen by the DUT.
  bit [7:0] mem [256];
  bit       mem_wr [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]    <= mem_wdata;
        mem_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  typedef struct {int core; bit we; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  txn_t exp_q[$];
  int   glog[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  // Reference model state.
  bit [7:0]   ref_mem [256];
  bit         ref_wr [256];
  logic       rst_smp = 1'b0;
  int         cyc = 0, m_idle_from = 0, m_mask_cyc = -100, m_mask_core = 0;
  int         m_gnt_cyc = -100, m_owner = 0, m_ptr = 0;
  logic [7:0] m_rdata = '0, m_maddr = '0, m_mwdata = '0;
  logic [3:0] prev_req = '0;
  int         done_cnt [4];
  int         gnt_cnt [4];

  always @(posedge clk) rst_smp <= resetARB;

  logic [3:0] elig, exp_gnt, exp_done;
  bit         exp_en, exp_busy, found, have;
  int         w, hit;
  txn_t       t;

  always @(negedge clk) begin
    cyc++;
    if (!rst_smp) begin
      m_idle_from = cyc;
      m_mask_cyc  = -100;
      m_gnt_cyc   = -100;
      m_ptr       = 0;
      m_rdata     = '0;
      m_maddr     = '0;
      m_mwdata    = '0;
      exp_q.delete();
    end
    exp_gnt = '0;
    if (cyc - 1 >= m_idle_from) begin
      elig = prev_req;
      if (cyc - 1 == m_mask_cyc) elig[m_mask_core] = 1'b0;
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && elig[(m_ptr + k) % 4]) begin
          found = 1'b1;
          w     = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        m_owner     = w;
        m_gnt_cyc   = cyc;
        m_idle_from = cyc + 3;
        m_mask_cyc  = cyc + 3;
        m_mask_core = w;
        exp_gnt[w]  = 1'b1;
      end
    end
    have = 1'b0;
    hit  = -1;
    t    = '{core: 0, we: 1'b0, addr: 8'h00, wdata: 8'h00};
    foreach (exp_q[i]) begin
      if (!have && exp_q[i].core == m_owner) begin
        have = 1'b1;
        hit  = i;
        t    = exp_q[i];
      end
    end
    exp_en   = (cyc == m_gnt_cyc + 1);
    exp_busy = (cyc >= m_gnt_cyc) && (cyc <= m_gnt_cyc + 2);
    exp_done = '0;
    if (exp_en) begin
      chk("txn_known", int'(have), 1);
      m_maddr  = t.addr;
      m_mwdata = t.wdata;
    end
    if (cyc == m_gnt_cyc + 2) begin
      exp_done[m_owner] = 1'b1;
      if (have) begin
        if (t.we) begin
          ref_mem[t.addr] = t.wdata;
          ref_wr[t.addr]  = 1'b1;
        end else begin
          m_rdata = ref_wr[t.addr] ? ref_mem[t.addr] : init_val(t.addr);
        end
        exp_q.delete(hit);
      end
      m_ptr = (m_owner + 1) % 4;
    end
    chk("gnt", int'(core_gnt), int'(exp_gnt));
    chk("mem_en", int'(mem_en), int'(exp_en));
    chk("mem_we", int'(mem_we), int'(exp_en && have && t.we));
    chk("mem_addr", int'(mem_addr), int'(m_maddr));
    chk("mem_wdata", int'(mem_wdata), int'(m_mwdata));
    chk("done", int'(core_done), int'(exp_done));
    chk("busy", int'(busy), int'(exp_busy));
    chk("owner", int'(owner), exp_busy ? m_owner : 0);
    chk("rdata", int'(core_rdata), int'(m_rdata));
    for (int c = 0; c < 4; c++) begin
      if (core_done[c]) done_cnt[c]++;
      if (core_gnt[c]) begin
        gnt_cnt[c]++;
        glog.push_back(c);
      end
    end
    prev_req = core_req;
  end

  // Driver state.
  bit pend [4], late_en [4], drop_next [4], early [4];
  int again [4], done_seen [4], gnt_seen [4];

  task automatic issue(input int c, input bit we, input logic [7:0] a, input logic [7:0] d);
    txn_t n;
    n.core = c; n.we = we; n.addr = a; n.wdata = d;
    exp_q.push_back(n);
    core_req[c]          = 1'b1;
    core_we[c]           = we;
    core_addr[c*8 +: 8]  = a;
    core_wdata[c*8 +: 8] = d;
    pend[c]              = 1'b1;
    drop_next[c]         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (drop_next[c]) begin
        core_req[c]  = 1'b0;
        drop_next[c] = 1'b0;
      end
      // Drop req and scramble fields after grant; the latched transaction must survive.
      if (early[c] && pend[c] && gnt_cnt[c] != gnt_seen[c]) begin
        core_req[c]          = 1'b0;
        core_we[c]           = ~core_we[c];
        core_addr[c*8 +: 8]  = ~core_addr[c*8 +: 8];
        core_wdata[c*8 +: 8] = ~core_wdata[c*8 +: 8];
      end
      gnt_seen[c] = gnt_cnt[c];
      if (done_cnt[c] != done_seen[c]) begin
        done_seen[c] = done_cnt[c];
        pend[c]      = 1'b0;
        if (late_en[c]) drop_next[c] = 1'b1;
        else core_req[c] = 1'b0;
        if (again[c] > 0) begin
          again[c]--;
          issue(c, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
      end
    end
  endtask

  function automatic bit any_pend();
    return pend[0] || pend[1] || pend[2] || pend[3];
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while ((any_pend() || core_req != 4'h0 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, int'(n < 200), 1);
  endtask

  task automatic wait_gnt(input int c);
    int n = 0;
    int s = gnt_cnt[c];
    while (gnt_cnt[c] == s && n < 50) begin
      tick();
      n++;
    end
    chk("gnt_timeout", int'(n < 50), 1);
  endtask

  task automatic clear_driver();
    core_req = '0;
    for (int c = 0; c < 4; c++) begin
      pend[c] = 1'b0; drop_next[c] = 1'b0; again[c] = 0; late_en[c] = 1'b0; early[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    resetARB = 1'b0;
    clear_driver();
    tick();
    resetARB = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int g, d_before;

  initial begin
    resetARB = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    clear_driver();
    repeat (3) tick();
    resetARB = 1'b1;
    tick();

    // Single read of a preloaded location.
    g = glog.size();
    issue(2, 1'b0, 8'h15, 8'h00);
    wait_idle("rd");
    chk("rd_core", glog_at(g), 2);
    chk("rd_data", int'(core_rdata), 'hA7);

    // Single write keeps core_rdata, then read it back.
    g = glog.size();
    issue(0, 1'b1, 8'h40, 8'h3C);
    wait_idle("wr");
    chk("wr_core", glog_at(g), 0);
    chk("wr_rdata_kept", int'(core_rdata), 'hA7);
    issue(1, 1'b0, 8'h40, 8'h00);
    wait_idle("wr_rb");
    chk("wr_readback", int'(core_rdata), 'h3C);

    // All four request from reset, each re-requests once.
    do_reset();
    tick();
    g = glog.size();
    for (int c = 0; c < 4; c++) begin
      again[c] = 1;
      issue(c, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    wait_idle("rr");
    for (int k = 0; k < 8; k++) chk("rr_order", glog_at(g + k), k % 4);

    // Core 3 streams, core 1 arrives during its service.
    g = glog.size();
    again[3] = 3;
    issue(3, 1'b0, 8'($urandom), 8'h00);
    wait_gnt(3);
    issue(1, 1'b1, 8'($urandom), 8'($urandom));
    wait_idle("fair");
    chk("fair_first", glog_at(g), 3);
    chk("fair_core1", glog_at(g + 1), 1);

    // Late deassert with another requester, then alone.
    g = glog.size();
    late_en[0] = 1'b1;
    issue(0, 1'b0, 8'($urandom), 8'h00);
    wait_gnt(0);
    issue(1, 1'b0, 8'($urandom), 8'h00);
    wait_idle("late");
    chk("late_next", glog_at(g + 1), 1);
    chk("late_count", glog.size() - g, 2);
    g = glog.size();
    late_en[2] = 1'b1;
    issue(2, 1'b1, 8'($urandom), 8'($urandom));
    wait_idle("late_solo");
    chk("late_solo_count", glog.size() - g, 1);
    late_en[0] = 1'b0;
    late_en[2] = 1'b0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && !core_req[c] && $urandom_range(0, 3) == 0) begin
          late_en[c] = ($urandom_range(0, 3) == 0);
          early[c]   = ($urandom_range(0, 5) == 0);
          issue(c, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
      end
    end
    wait_idle("rand");
    clear_driver();

    // Reset during ACCESS aborts the transaction.
    d_before = done_cnt[2];
    issue(2, 1'b0, 8'($urandom), 8'h00);
    for (int n = 0; n < 20 && !mem_en; n++) tick();
    chk("abort_reached_access", int'(mem_en), 1);
    do_reset();
    chk("abort_busy", int'(busy), 0);
    chk("abort_en", int'(mem_en), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_rdata", int'(core_rdata), 0);
    tick();
    g = glog.size();
    issue(1, 1'b1, 8'($urandom), 8'($urandom));
    wait_idle("abort");
    chk("abort_no_done", done_cnt[2], d_before);
    chk("abort_regrant", glog_at(g), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NCORES, default 4, number of requesting cores; fixed at 4 for this release.
REQ-002 Parameter AW, default 8, memory address width.
REQ-003 Parameter DW, default 8, memory data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetARB  input  1  reset, synchronous, active-low.
REQ-006 core_req  input  4  per-core access request, level.
REQ-007 core_we  input  4  per-core write (1) / read (0) select.
REQ-008 core_addr  input  4*AW  per-core address; core i at bits [i*AW +: AW].
REQ-009 core_wdata  input  4*DW  per-core write data; core i at bits [i*DW +: DW].
REQ-010 core_gnt  output  4  one-hot grant pulse.
REQ-011 core_done  output  4  one-hot completion pulse.
REQ-012 core_rdata  output  DW  read data, shared by all cores.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  AW  memory address.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  synchronous memory read data, valid one cycle after mem_en.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 owner  output  2  index of the core currently served; 0 in IDLE.

Function
REQ-020 Four-state FSM, registered outputs:
- IDLE -> GRANT when any eligible request is present, else stay IDLE.
- GRANT -> ACCESS.
- ACCESS -> RESP.
- RESP -> IDLE.
REQ-021 Arbitration in IDLE only: winner = first set bit of eligible core_req, scanning from index ptr upward modulo 4.
REQ-022 Round-robin pointer ptr (2 bits):
- reset value 0.
- on leaving RESP, ptr <= owner+1; wraps 3 -> 0.
REQ-023 On IDLE->GRANT, latch owner, the winner's we, addr and wdata; later changes on core inputs do not affect the transaction.
REQ-024 GRANT state: core_gnt[owner]=1 for exactly one cycle; all memory outputs inactive.
REQ-025 ACCESS state:
- mem_en=1 for exactly one cycle.
- mem_we = latched we.
- mem_addr and mem_wdata = latched values.
REQ-026 RESP state:
- core_done[owner]=1 for exactly one cycle.
- on a read, core_rdata <= mem_rdata at entry to RESP and holds until the next read completes.
- on a write, core_rdata is unchanged.
REQ-027 Latency: request sampled in IDLE at edge k gives GRANT in cycle k+1, ACCESS in k+2, and RESP (done, rdata valid) in k+3; minimum 4 cycles per transaction.
REQ-028 Requester protocol: hold req/we/addr/wdata until core_done, then deassert req at the edge that samples core_done.
REQ-029 Eligibility mask: in the first IDLE cycle after RESP, the previous owner's core_req is masked, so a late deassert does not cause a double grant.
REQ-030 A requester dropping req after grant does not abort the transaction; it completes and core_done still pulses.
REQ-031 Simultaneous requests are served one per transaction in round-robin order; no core waits more than 3 other transactions.
REQ-032 At most one bit of core_gnt and of core_done is set in any cycle; core_gnt and core_done are never high in the same cycle.
REQ-033 When not in ACCESS: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.

Reset
REQ-034 resetARB low at a rising edge sets:
- state = IDLE, ptr = 0, owner = 0, busy = 0.
- core_gnt = 0, core_done = 0, core_rdata = 0.
- mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-035 Reset mid-transaction aborts it: no further mem_en and no core_done; arbitration resumes from ptr=0 on the first edge with resetARB high.

Verification
REQ-036 Single read: core 2 reads addr 0x15, mem holds 0xA7 -> gnt[2] in cycle 1, mem_en with mem_addr=0x15 in cycle 2, done[2] with core_rdata=0xA7 in cycle 3.
REQ-037 Single write: core 0 writes 0x3C to 0x40 -> mem_we=1, mem_addr=0x40, mem_wdata=0x3C for one cycle; done[0]; core_rdata unchanged.
REQ-038 Contention: all 4 cores request at once from reset -> service order 0,1,2,3; each core requests again immediately -> next round order 0,1,2,3, with ptr wrap 3->0.
REQ-039 Fairness: core 3 requests continuously, core 1 requests once while core 3 is served -> core 1 is served before core 3's second grant.
REQ-040 Reset abort: resetARB low during ACCESS -> no core_done; outputs as in REQ-034; a new request after release is granted 1 cycle later.
REQ-041 Late deassert: owner keeps req high for one cycle after done while core 1 requests -> core 1 is granted next; no repeat grant to the owner.
